// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs decoded field descriptors back into 32-bit words
// and streams them out as {addr, instr} through a single registered output slot.
module instr_encoder #(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [3:0]        s_cls,
   input  logic [2:0]        s_funct3,
   input  logic              s_f7b5,
   input  logic [4:0]        s_rd,
   input  logic [4:0]        s_rs1,
   input  logic [4:0]        s_rs2,
   input  logic [31:0]       s_imm,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [31:0]       m_instr,
   output logic [ADDR_W-1:0] m_addr,
   output logic [15:0]       count,
   output logic              err,
   output logic [2:0]        err_code
);

   typedef enum logic [3:0] {
      CLS_LOAD   = 4'd0,
      CLS_OPIMM  = 4'd1,
      CLS_AUIPC  = 4'd2,
      CLS_STORE  = 4'd3,
      CLS_OP     = 4'd4,
      CLS_LUI    = 4'd5,
      CLS_BRANCH = 4'd6,
      CLS_JALR   = 4'd7,
      CLS_JAL    = 4'd8
   } cls_e;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   localparam logic [2:0] ERR_NONE  = 3'd0;
   localparam logic [2:0] ERR_CLS   = 3'd1;
   localparam logic [2:0] ERR_F3    = 3'd2;
   localparam logic [2:0] ERR_RANGE = 3'd3;
   localparam logic [2:0] ERR_ALIGN = 3'd4;

   logic signed [31:0] imm_s;
   logic               fits_i;
   logic               fits_b;
   logic               fits_j;
   logic               fits_u;
   logic               fits_sh;
   logic               is_shift;
   logic [11:0]        imm_i;
   logic [31:0]        enc_instr;
   logic [2:0]         enc_code;
   logic               pop;
   logic               accept;

   assign imm_s    = s_imm;
   assign fits_i   = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
   assign fits_b   = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094);
   assign fits_j   = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574);
   assign fits_u   = (s_imm[11:0] == 12'd0);
   assign fits_sh  = (s_imm[31:5] == 27'd0);
   assign is_shift = (s_funct3 == 3'b001) || (s_funct3 == 3'b101);
   assign imm_i    = is_shift ? {1'b0, s_f7b5, 5'b0, s_imm[4:0]} : s_imm[11:0];

   // Field packing and legality; each class checks funct3 first, then range, then alignment.
   always_comb begin
      enc_instr = '0;
      enc_code  = ERR_NONE;
      case (s_cls)
         CLS_LOAD: begin
            enc_instr = {s_imm[11:0], s_rs1, s_funct3, s_rd, OPC_LOAD};
            if (s_funct3 == 3'b011 || s_funct3 == 3'b110 || s_funct3 == 3'b111) enc_code = ERR_F3;
            else if (!fits_i) enc_code = ERR_RANGE;
         end
         CLS_OPIMM: begin
            enc_instr = {imm_i, s_rs1, s_funct3, s_rd, OPC_OPIMM};
            if (s_f7b5 && s_funct3 != 3'b101) enc_code = ERR_F3;
            else if (is_shift ? !fits_sh : !fits_i) enc_code = ERR_RANGE;
         end
         CLS_AUIPC: begin
            enc_instr = {s_imm[31:12], s_rd, OPC_AUIPC};
            if (!fits_u) enc_code = ERR_RANGE;
         end
         CLS_STORE: begin
            enc_instr = {s_imm[11:5], s_rs2, s_rs1, s_funct3, s_imm[4:0], OPC_STORE};
            if (s_funct3 > 3'b010) enc_code = ERR_F3;
            else if (!fits_i) enc_code = ERR_RANGE;
         end
         CLS_OP: begin
            enc_instr = {1'b0, s_f7b5, 5'b0, s_rs2, s_rs1, s_funct3, s_rd, OPC_OP};
            if (s_f7b5 && !(s_funct3 == 3'b000 || s_funct3 == 3'b101)) enc_code = ERR_F3;
         end
         CLS_LUI: begin
            enc_instr = {s_imm[31:12], s_rd, OPC_LUI};
            if (!fits_u) enc_code = ERR_RANGE;
         end
         CLS_BRANCH: begin
            enc_instr = {s_imm[12], s_imm[10:5], s_rs2, s_rs1, s_funct3,
                         s_imm[4:1], s_imm[11], OPC_BRANCH};
            if (s_funct3 == 3'b010 || s_funct3 == 3'b011) enc_code = ERR_F3;
            else if (!fits_b) enc_code = ERR_RANGE;
            else if (s_imm[0]) enc_code = ERR_ALIGN;
         end
         CLS_JALR: begin
            enc_instr = {s_imm[11:0], s_rs1, s_funct3, s_rd, OPC_JALR};
            if (s_funct3 != 3'b000) enc_code = ERR_F3;
            else if (!fits_i) enc_code = ERR_RANGE;
         end
         CLS_JAL: begin
            enc_instr = {s_imm[20], s_imm[10:1], s_imm[11], s_imm[19:12], s_rd, OPC_JAL};
            if (!fits_j) enc_code = ERR_RANGE;
            else if (s_imm[0]) enc_code = ERR_ALIGN;
         end
         default: enc_code = ERR_CLS;
      endcase
   end

   assign s_ready = ~flush & (~m_valid | m_ready);
   assign accept  = s_valid & s_ready;
   assign pop     = m_valid & m_ready;

   // Output slot: pop advances address/count, a legal accept reloads in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid  <= 1'b0;
         m_instr  <= '0;
         m_addr   <= BASE_ADDR;
         count    <= '0;
         err      <= 1'b0;
         err_code <= ERR_NONE;
      end else if (flush) begin
         m_valid <= 1'b0;
         m_addr  <= BASE_ADDR;
         count   <= '0;
         err     <= 1'b0;
      end else begin
         err <= 1'b0;
         if (pop) begin
            m_addr <= m_addr + ADDR_W'(4);
            if (count != 16'hFFFF) count <= count + 16'd1;
         end
         if (accept && enc_code == ERR_NONE) begin
            m_valid <= 1'b1;
            m_instr <= enc_instr;
         end else if (pop) begin
            m_valid <= 1'b0;
         end
         if (accept && enc_code != ERR_NONE) begin
            err      <= 1'b1;
            err_code <= enc_code;
         end
      end
   end

endmodule
